// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-rate game-state sequencer driving logo, head and coin layer offsets
// Optional SCENE_HOLD_LANE_EN: head hoffset follows held debounced buttons instead of stepping lanes.
module scene_sequencer #(
   parameter int COUNTDOWN_FRAMES = 45,
   parameter int LOGO_STEP        = 30,
   parameter int LOGO_END         = -600,
   parameter int HEAD_START       = -170,
   parameter int HEAD_STEP        = 17,
   parameter int LANE_OFFSET      = 100,
   parameter int COIN_FRAMES      = 60,
   parameter int DEBOUNCE_CYCLES  = 1000000
) (
   input  logic               CLK100MHZ,
   input  logic               CPU_RESETN,
   input  logic               vsync,
   input  logic               BTNL,
   input  logic               BTNR,
   output logic               frame_tick,
   output logic [1:0]         state,
   output logic signed [11:0] logo_hoffset,
   output logic signed [11:0] head_voffset,
   output logic signed [11:0] head_hoffset,
   output logic signed [11:0] coin_hoffset,
   output logic signed [11:0] coin_voffset
);
   typedef enum logic [1:0] {
      COUNTDOWN   = 2'd0,
      LOGO_SCROLL = 2'd1,
      HEAD_DROP   = 2'd2,
      RUN         = 2'd3
   } state_t;

   localparam int CW = $clog2(COUNTDOWN_FRAMES + 1);
   localparam int NW = $clog2(COIN_FRAMES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]        CD_INIT     = CW'(COUNTDOWN_FRAMES);
   localparam logic [CW-1:0]        CD_ONE      = CW'(1);
   localparam logic [NW-1:0]        N_LAST      = NW'(COIN_FRAMES - 1);
   localparam logic [DW-1:0]        DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic signed [12:0]   LOGO_END_X  = 13'(LOGO_END);
   localparam logic signed [12:0]   LOGO_STEP_X = 13'(LOGO_STEP);
   localparam logic signed [12:0]   HEAD_STEP_X = 13'(HEAD_STEP);
   localparam logic signed [11:0]   HEAD_INIT   = 12'(HEAD_START);
   localparam logic signed [11:0]   LANE_POS    = 12'(LANE_OFFSET);
   localparam logic signed [11:0]   LANE_NEG    = 12'(-LANE_OFFSET);
   localparam logic signed [11:0]   COIN_H0     = -12'sd200;
   localparam logic signed [11:0]   COIN_V0     = -12'sd40;

   // vsync synchroniser and rising-edge detect
   logic vs_s1_q, vs_s2_q, vs_prev_q, tick_int;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         vs_s1_q   <= 1'b0;
         vs_s2_q   <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         vs_s1_q   <= vsync;
         vs_s2_q   <= vs_s1_q;
         vs_prev_q <= vs_s2_q;
      end
   end

   assign tick_int = vs_s2_q & ~vs_prev_q;

   // button synchronisers and debouncers; index 0 = BTNL, 1 = BTNR
   logic [1:0]    btn_s1_q, btn_s2_q, deb_q, deb_d;
   logic [DW-1:0] db_cnt_q [2];
   logic [DW-1:0] db_cnt_d [2];

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (btn_s2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) deb_d[i] = btn_s2_q[i];
            else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         deb_q    <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         btn_s1_q <= {BTNR, BTNL};
         btn_s2_q <= btn_s1_q;
         deb_q    <= deb_d;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   // scene FSM and per-frame offsets
   state_t                state_q, state_d;
   logic [CW-1:0]         cd_q, cd_d;
   logic signed [11:0]    logo_q, logo_d;
   logic signed [11:0]    head_v_q, head_v_d;
   logic [NW-1:0]         n_q, n_d;
   logic signed [11:0]    coin_h_q, coin_h_d;
   logic signed [11:0]    coin_v_q, coin_v_d;
   logic                  frame_tick_q;
   logic signed [12:0]    logo_sum, head_sum;

   always_comb begin
      state_d  = state_q;
      cd_d     = cd_q;
      logo_d   = logo_q;
      head_v_d = head_v_q;
      n_d      = n_q;
      // one guard bit so the clamps compare before 12-bit wrap
      logo_sum = {logo_q[11], logo_q} - LOGO_STEP_X;
      head_sum = {head_v_q[11], head_v_q} + HEAD_STEP_X;
      if (tick_int) begin
         case (state_q)
            COUNTDOWN: begin
               if (cd_q <= CD_ONE) begin
                  cd_d    = '0;
                  state_d = LOGO_SCROLL;
               end else begin
                  cd_d = cd_q - 1'b1;
               end
            end
            LOGO_SCROLL: begin
               if (logo_sum <= LOGO_END_X) begin
                  logo_d  = LOGO_END_X[11:0];
                  state_d = HEAD_DROP;
               end else begin
                  logo_d = logo_sum[11:0];
               end
            end
            HEAD_DROP: begin
               if (head_sum >= 13'sd0) begin
                  head_v_d = '0;
                  state_d  = RUN;
               end else begin
                  head_v_d = head_sum[11:0];
               end
            end
            RUN: n_d = (n_q == N_LAST) ? '0 : n_q + 1'b1;
            default: state_d = state_q;
         endcase
      end
      coin_h_d = COIN_H0 + 12'(n_d);
      coin_v_d = COIN_V0 - 12'(n_d) * 12'sd6;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q      <= COUNTDOWN;
         cd_q         <= CD_INIT;
         logo_q       <= '0;
         head_v_q     <= HEAD_INIT;
         n_q          <= '0;
         coin_h_q     <= COIN_H0;
         coin_v_q     <= COIN_V0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cd_q         <= cd_d;
         logo_q       <= logo_d;
         head_v_q     <= head_v_d;
         n_q          <= n_d;
         coin_h_q     <= coin_h_d;
         coin_v_q     <= coin_v_d;
         frame_tick_q <= tick_int;
      end
   end

   logic signed [11:0] head_h;

`ifdef SCENE_HOLD_LANE_EN
   always_comb begin
      head_h = '0;
      if (state_q == RUN) begin
         if (deb_q[0])      head_h = LANE_POS;
         else if (deb_q[1]) head_h = LANE_NEG;
      end
   end
`else
   logic [1:0] deb_prev_q, press;
   logic [1:0] lane_q, lane_d;

   assign press = deb_q & ~deb_prev_q;

   // simultaneous left and right presses cancel; presses outside RUN are dropped
   always_comb begin
      lane_d = lane_q;
      if (state_q == RUN) begin
         if (press[0] && !press[1] && lane_q != 2'd0)      lane_d = lane_q - 1'b1;
         else if (press[1] && !press[0] && lane_q != 2'd2) lane_d = lane_q + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         deb_prev_q <= '0;
         lane_q     <= 2'd1;
      end else begin
         deb_prev_q <= deb_q;
         lane_q     <= lane_d;
      end
   end

   always_comb begin
      head_h = '0;
      case (lane_q)
         2'd0:    head_h = LANE_POS;
         2'd2:    head_h = LANE_NEG;
         default: head_h = '0;
      endcase
   end
`endif

   assign frame_tick   = frame_tick_q;
   assign state        = state_q;
   assign logo_hoffset = logo_q;
   assign head_voffset = head_v_q;
   assign head_hoffset = head_h;
   assign coin_hoffset = coin_h_q;
   assign coin_voffset = coin_v_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - randomized self-checking bench for scene_sequencer against a frame-count model
module tb_scene_sequencer;
   localparam int DEB  = 4;
   localparam int LANE = 100;
   localparam int T1   = 45;
   localparam int T2   = T1 + (600 + 30 - 1) / 30;
   localparam int T3   = T2 + (170 + 17 - 1) / 17;

   logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, btnl = 1'b0, btnr = 1'b0;
   logic               frame_tick;
   logic [1:0]         state;
   logic signed [11:0] logo, headv, headh, coinh, coinv;

   int checks = 0, errors = 0;
   int cyc = 0, k = 0;
   int tick_q[$];
   bit settle = 1'b0;
   int exp_headh = 0;
   int lane = 1;

   scene_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .vsync(vsync), .BTNL(btnl), .BTNR(btnr),
      .frame_tick(frame_tick), .state(state), .logo_hoffset(logo), .head_voffset(headv),
      .head_hoffset(headh), .coin_hoffset(coinh), .coin_voffset(coinv)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endfunction

   // expected outputs as a function of frames seen since reset
   function automatic int m_state(int f);
      if (f < T1) return 0;
      if (f < T2) return 1;
      if (f < T3) return 2;
      return 3;
   endfunction
   function automatic int m_logo(int f);
      int v;
      if (f <= T1) return 0;
      v = -30 * (f - T1);
      return (v < -600) ? -600 : v;
   endfunction
   function automatic int m_headv(int f);
      int v;
      if (f <= T2) return -170;
      v = -170 + 17 * (f - T2);
      return (v > 0) ? 0 : v;
   endfunction
   function automatic int m_n(int f);
      return (f < T3) ? 0 : (f - T3) % 60;
   endfunction

   initial begin : cmp
      int et;
      forever begin
         @(negedge clk);
         et = 0;
         if (!rst_n) begin
            k = 0;
            tick_q.delete();
         end else if (tick_q.size() > 0 && tick_q[0] == cyc) begin
            void'(tick_q.pop_front());
            k++;
            et = 1;
         end
         chk("frame_tick", int'(frame_tick), et);
         chk("state", int'(state), m_state(k));
         chk("logo_hoffset", int'(logo), m_logo(k));
         chk("head_voffset", int'(headv), m_headv(k));
         chk("coin_hoffset", int'(coinh), -200 + m_n(k));
         chk("coin_voffset", int'(coinv), -40 - 6 * m_n(k));
         if (!settle) chk("head_hoffset", int'(headh), exp_headh);
      end
   end

   task automatic vs_pulse();
      @(negedge clk);
      vsync = 1'b1;
      tick_q.push_back(cyc + 3);
      repeat ($urandom_range(2, 5)) @(negedge clk);
      vsync = 1'b0;
      repeat ($urandom_range(3, 6)) @(negedge clk);
   endtask

   task automatic ticks(int n);
      int b;
      for (int i = 0; i < n; i++) vs_pulse();
      b = 0;
      while (tick_q.size() != 0 && b < 20) begin
         @(negedge clk);
         b++;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic btn_op(bit l, bit r, int hold);
      int held, rel;
      if (hold >= 8) begin
`ifdef SCENE_HOLD_LANE_EN
         held = (m_state(k) == 3) ? (l ? LANE : (r ? -LANE : 0)) : 0;
         rel  = 0;
`else
         if (m_state(k) == 3) begin
            if (l && !r && lane > 0)      lane--;
            else if (r && !l && lane < 2) lane++;
         end
         held = (1 - lane) * LANE;
         rel  = held;
`endif
      end else begin
         held = exp_headh;
         rel  = exp_headh;
      end
      @(negedge clk);
      settle = 1'b1;
      btnl = l;
      btnr = r;
      repeat (hold) @(negedge clk);
      #1 chk("head_held", int'(headh), held);
      btnl = 1'b0;
      btnr = 1'b0;
      repeat (8) @(negedge clk);
      #1 chk("head_released", int'(headh), rel);
      exp_headh = rel;
      settle = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_headv", int'(headv), -170);
      chk("rst_coinv", int'(coinv), -40);
      rst_n = 1'b1;

      btn_op(1'b1, 1'b0, 10);
      ticks(44);
      chk("cd_44_state", int'(state), 0);
      ticks(1);
      chk("cd_45_state", int'(state), 1);
      chk("cd_45_logo", int'(logo), 0);
      ticks(10);
      chk("logo_10", int'(logo), -300);

      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_logo", int'(logo), 0);
      chk("arst_headv", int'(headv), -170);
      chk("arst_headh", int'(headh), 0);
      chk("arst_coinh", int'(coinh), -200);
      chk("arst_coinv", int'(coinv), -40);
      chk("arst_tick", int'(frame_tick), 0);
      lane = 1;
      exp_headh = 0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;

      ticks(T2);
      chk("logo_end", int'(logo), -600);
      chk("logo_end_state", int'(state), 2);
      ticks(9);
      chk("head_9", int'(headv), -17);
      ticks(1);
      chk("head_10", int'(headv), 0);
      chk("head_10_state", int'(state), 3);
      ticks(59);
      chk("coin59_h", int'(coinh), -141);
      chk("coin59_v", int'(coinv), -394);
      ticks(1);
      chk("coin_wrap_h", int'(coinh), -200);
      chk("coin_wrap_v", int'(coinv), -40);

      @(negedge clk);
      vsync = 1'b1;
      tick_q.push_back(cyc + 3);
      @(posedge clk); #1 chk("lat_e1", int'(frame_tick), 0);
      @(posedge clk); #1 chk("lat_e2", int'(frame_tick), 0);
      @(posedge clk); #1 chk("lat_e3", int'(frame_tick), 1);
      @(posedge clk); #1 chk("lat_e4", int'(frame_tick), 0);
      vsync = 1'b0;
      ticks(0);

      btn_op(1'b1, 1'b0, 10);
      btn_op(1'b1, 1'b0, 10);
      btn_op(1'b0, 1'b1, 10);
      btn_op(1'b0, 1'b1, 10);
      btn_op(1'b1, 1'b0, 3);
      btn_op(1'b1, 1'b1, 10);

      for (int i = 0; i < 30; i++) begin
         int sel;
         sel = $urandom_range(0, 3);
         case (sel)
            0: btn_op(1'b1, 1'b0, $urandom_range(8, 12));
            1: btn_op(1'b0, 1'b1, $urandom_range(8, 12));
            2: btn_op(1'b1, 1'b1, $urandom_range(8, 12));
            default: btn_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 3));
         endcase
         ticks($urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
